// File: rtl/rreg_cell.sv
// Generic WIDTH-bit flop stage: synchronous active-high reset, optional load enable.
// Reset has priority over enable; q is purely registered.
module rreg_cell #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               HAS_EN    = 1
) (
  input  logic             eph1,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 1) begin : g_width_check
    $fatal(1, "rreg_cell: WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Without an enable the cell loads every cycle and en is never looked at.
  always_comb begin
    q_d = d;
    if ((HAS_EN != 0) && !en) begin
      q_d = q_q;
    end
  end

  always_ff @(posedge eph1) begin
    if (reset) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

`ifdef SIM
  always @(posedge eph1) begin
    assert (!$isunknown(reset))
      else $error("rreg_cell: reset is X/Z");
    if ((HAS_EN != 0) && (reset === 1'b0)) begin
      assert (!$isunknown(en))
        else $error("rreg_cell: en is X/Z while enabled loading is in use");
    end
  end
`endif

endmodule

// File: tb/tb_rreg_cell.sv
// Self-checking bench for rreg_cell: wide enabled stage, priority, counter feedback,
// 11-stage chain and enable-less variant, each against a behavioural model.
module tb_rreg_cell;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam int NST = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 128-bit enabled stage
  logic         r128, e128;
  logic [127:0] d128, q128;
  rreg_cell #(.WIDTH(128), .RESET_VAL(128'h0), .HAS_EN(1)) u_w128 (
    .eph1(clk), .reset(r128), .en(e128), .d(d128), .q(q128));

  // 4-bit enabled stage with non-zero reset value
  logic       rp, ep;
  logic [3:0] dp, qp;
  rreg_cell #(.WIDTH(4), .RESET_VAL(4'ha), .HAS_EN(1)) u_prio (
    .eph1(clk), .reset(rp), .en(ep), .d(dp), .q(qp));

  // 4-bit free-running down-counter
  logic       rc;
  logic [3:0] dc, qc;
  assign dc = qc - 4'd1;
  rreg_cell #(.WIDTH(4), .RESET_VAL(4'ha), .HAS_EN(0)) u_cnt (
    .eph1(clk), .reset(rc), .en(1'b0), .d(dc), .q(qc));

  // 11-stage byte chain sharing one enable
  logic       rch, ech;
  logic [7:0] din;
  logic [7:0] chd [NST];
  logic [7:0] chq [NST];
  assign chd[0] = din;
  for (genvar g = 0; g < NST; g++) begin : g_chain
    if (g > 0) begin : g_link
      assign chd[g] = chq[g-1];
    end
    rreg_cell #(.WIDTH(8), .RESET_VAL(8'h00), .HAS_EN(1)) u_st (
      .eph1(clk), .reset(rch), .en(ech), .d(chd[g]), .q(chq[g]));
  end

  // 16-bit stage without enable
  logic        rne, ene;
  logic [15:0] dne, qne;
  rreg_cell #(.WIDTH(16), .RESET_VAL(16'h0), .HAS_EN(0)) u_noen (
    .eph1(clk), .reset(rne), .en(ene), .d(dne), .q(qne));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    r128 = 1'b1; e128 = 1'b1; d128 = K2;
    rp = 1'b1; ep = 1'b0; dp = 4'h3;
    rc = 1'b1;
    rch = 1'b1; ech = 1'b0; din = 8'h00;
    rne = 1'b1; ene = 1'b0; dne = 16'hffff;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (q128 !== 128'h0) begin
        errors++; $display("FAIL reset_w128 cyc%0d got=%h exp=0", i, q128);
      end
      checks++;
      if (qp !== 4'ha) begin
        errors++; $display("FAIL reset_prio cyc%0d got=%h exp=a", i, qp);
      end
      checks++;
      if (qc !== 4'ha) begin
        errors++; $display("FAIL reset_cnt cyc%0d got=%h exp=a", i, qc);
      end
    end
    checks++;
    if (chq[0] !== 8'h00 || chq[NST-1] !== 8'h00) begin
      errors++; $display("FAIL reset_chain got=%h/%h exp=00/00", chq[0], chq[NST-1]);
    end
    checks++;
    if (qne !== 16'h0) begin
      errors++; $display("FAIL reset_noen got=%h exp=0", qne);
    end
    rch = 1'b0;
    rne = 1'b0;
  endtask

  task automatic test_load();
    logic [127:0] exp_q;
    r128 = 1'b0; e128 = 1'b1; d128 = K1;
    tick();
    checks++;
    if (q128 !== K1) begin
      errors++; $display("FAIL load_k1 got=%h exp=%h", q128, K1);
    end
    exp_q = K1;
    for (int i = 0; i < 40; i++) begin
      r128 = (($urandom % 8) == 0);
      e128 = $urandom % 2;
      d128 = {$urandom, $urandom, $urandom, $urandom};
      if (r128) exp_q = '0;
      else if (e128) exp_q = d128;
      tick();
      checks++;
      if (q128 !== exp_q) begin
        errors++;
        $display("FAIL load_rand it%0d rst=%0b en=%0b got=%h exp=%h", i, r128, e128, q128, exp_q);
      end
    end
    r128 = 1'b0;
  endtask

  task automatic test_hold();
    e128 = 1'b1; d128 = K1;
    tick();
    e128 = 1'b0; d128 = K2;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (q128 !== K1) begin
        errors++; $display("FAIL hold cyc%0d got=%h exp=%h", i, q128, K1);
      end
    end
    e128 = 1'b1;
    tick();
    checks++;
    if (q128 !== K2) begin
      errors++; $display("FAIL hold_release got=%h exp=%h", q128, K2);
    end
    e128 = 1'b0;
  endtask

  task automatic test_priority();
    r128 = 1'b1; e128 = 1'b1; d128 = '1;
    tick();
    checks++;
    if (q128 !== 128'h0) begin
      errors++; $display("FAIL prio_w128 got=%h exp=0", q128);
    end
    r128 = 1'b0; e128 = 1'b0;
    rp = 1'b0; ep = 1'b1; dp = 4'h3;
    tick();
    checks++;
    if (qp !== 4'h3) begin
      errors++; $display("FAIL prio4_load got=%h exp=3", qp);
    end
    rp = 1'b1; ep = 1'b1; dp = 4'hf;
    tick();
    checks++;
    if (qp !== 4'ha) begin
      errors++; $display("FAIL prio4_reset got=%h exp=a", qp);
    end
    rp = 1'b0; ep = 1'b0;
  endtask

  task automatic test_counter();
    int exp_c;
    exp_c = 10;
    rc = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      exp_c = (exp_c + 15) % 16;
      checks++;
      if (qc !== exp_c[3:0]) begin
        errors++; $display("FAIL count step%0d got=%h exp=%h", k, qc, exp_c[3:0]);
      end
    end
    for (int k = 0; k < 16 && exp_c != 5; k++) begin
      tick();
      exp_c = (exp_c + 15) % 16;
    end
    checks++;
    if (qc !== 4'h5) begin
      errors++; $display("FAIL count_pre_reset got=%h exp=5", qc);
    end
    rc = 1'b1;
    tick();
    checks++;
    if (qc !== 4'ha) begin
      errors++; $display("FAIL count_mid_reset got=%h exp=a", qc);
    end
    rc = 1'b0;
    tick();
    checks++;
    if (qc !== 4'h9) begin
      errors++; $display("FAIL count_resume got=%h exp=9", qc);
    end
  endtask

  task automatic test_chain();
    logic [7:0] mdl [NST];
    for (int i = 0; i < NST; i++) mdl[i] = 8'h00;
    for (int v = 1; v <= NST; v++) begin
      din = 8'(v); ech = 1'b1;
      tick();
      for (int i = NST - 1; i > 0; i--) mdl[i] = mdl[i-1];
      mdl[0] = 8'(v);
      ech = 1'b0;
      for (int j = 0; j < 1 + ($urandom % 3); j++) begin
        din = 8'($urandom);
        tick();
        for (int i = 0; i < NST; i++) begin
          checks++;
          if (chq[i] !== mdl[i]) begin
            errors++; $display("FAIL chain_idle v%0d st%0d got=%h exp=%h", v, i, chq[i], mdl[i]);
          end
        end
      end
    end
    checks++;
    if (chq[NST-1] !== 8'd1) begin
      errors++; $display("FAIL chain_last got=%0d exp=1", chq[NST-1]);
    end
    checks++;
    if (chq[0] !== 8'd11) begin
      errors++; $display("FAIL chain_first got=%0d exp=11", chq[0]);
    end
  endtask

  task automatic test_no_en();
    logic [15:0] prev;
    for (int i = 0; i < 40; i++) begin
      case ($urandom % 3)
        0: ene = 1'b0;
        1: ene = 1'b1;
        default: ene = 1'bx;
      endcase
      dne = 16'($urandom);
      prev = dne;
      tick();
      checks++;
      if (qne !== prev) begin
        errors++; $display("FAIL noen it%0d got=%h exp=%h", i, qne, prev);
      end
    end
    ene = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_load();
    test_hold();
    test_priority();
    test_counter();
    test_chain();
    test_no_en();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
